tournament_scheduler: RTL and testbench

//  Sequences binary tournament selection for the GA core: draws two distinct random

---
 rtl/tournament_scheduler.sv | 104 ++++++++++
 tb/tb_tournament_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tournament_scheduler.sv
// tournament_scheduler: binary tournament selection sequencer for the GA core.
// Draws two distinct LFSR indices, fetches their fitness, runs the comparator and streams winners.
module tournament_scheduler #(
    parameter int          POP_SIZE      = 16,
    parameter int          IDX_WIDTH     = 4,
    parameter int          FITNESS_WIDTH = 27,
    parameter int          CNT_WIDTH     = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [CNT_WIDTH-1:0]     num_parents,
    output logic                     fit_rd_en,
    output logic [IDX_WIDTH-1:0]     fit_addr,
    input  logic [FITNESS_WIDTH-1:0] fit_data,
    output logic                     cmp_en,
    output logic [FITNESS_WIDTH-1:0] cmp_fitness1,
    output logic [FITNESS_WIDTH-1:0] cmp_fitness2,
    input  logic                     cmp_selected,
    output logic                     winner_valid,
    input  logic                     winner_ready,
    output logic [IDX_WIDTH-1:0]     winner_idx,
    output logic                     busy,
    output logic                     done
);
    localparam logic [2:0] IDLE = 3'd0, PICK = 3'd1, RD_A = 3'd2, RD_B = 3'd3,
                           CAP_B = 3'd4, CMP = 3'd5, RES = 3'd6, OUT = 3'd7;
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(POP_SIZE - 1);

    logic [2:0]               state;
    logic [15:0]              lfsr, lfsr_next;
    logic [IDX_WIDTH-1:0]     idx_a, idx_b, draw_a, draw_b;
    logic [CNT_WIDTH-1:0]     count, target;
    logic                     last;

    always_comb begin
        draw_a    = lfsr[IDX_WIDTH-1:0];
        draw_b    = (lfsr[2*IDX_WIDTH-1:IDX_WIDTH] != draw_a) ? lfsr[2*IDX_WIDTH-1:IDX_WIDTH] :
                    (draw_a == LAST_IDX) ? '0 : draw_a + IDX_WIDTH'(1);
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        last      = (count + CNT_WIDTH'(1)) == target;
    end

    assign fit_rd_en    = (state == RD_A) || (state == RD_B);
    assign fit_addr     = (state == RD_A) ? idx_a : (state == RD_B) ? idx_b : '0;
    assign cmp_en       = state == CMP;
    assign winner_valid = state == OUT;
    assign busy         = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lfsr         <= SEED;
            idx_a        <= '0;
            idx_b        <= '0;
            count        <= '0;
            target       <= '0;
            cmp_fitness1 <= '0;
            cmp_fitness2 <= '0;
            winner_idx   <= '0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (num_parents != '0) begin
                        target <= num_parents;
                        count  <= '0;
                        state  <= PICK;
                    end else begin
                        done <= 1'b1;
                    end
                end
                PICK: begin
                    idx_a <= draw_a;
                    idx_b <= draw_b;
                    lfsr  <= lfsr_next;
                    state <= RD_A;
                end
                RD_A:  state <= RD_B;
                RD_B: begin
                    cmp_fitness1 <= fit_data;
                    state        <= CAP_B;
                end
                CAP_B: begin
                    cmp_fitness2 <= fit_data;
                    state        <= CMP;
                end
                CMP:   state <= RES;
                RES: begin
                    winner_idx <= cmp_selected ? idx_b : idx_a;
                    state      <= OUT;
                end
                OUT: if (winner_ready) begin
                    count <= count + CNT_WIDTH'(1);
                    done  <= last;
                    state <= last ? IDLE : PICK;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tournament_scheduler.sv
// tb_tournament_scheduler: directed/randomized bench with a draw-level reference model
// of the LFSR index picks, fitness RAM and tie-to-B comparator.
module tb_tournament_scheduler;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, start2 = 1'b0;
    logic [7:0]  num_parents = '0;
    logic        fit_rd_en, cmp_en, cmp_selected, winner_valid, busy, done;
    logic        winner_ready = 1'b0;
    logic [3:0]  fit_addr, winner_idx;
    logic [26:0] fit_data = '0, cmp_fitness1, cmp_fitness2;
    logic        fit_rd_en2, cmp_en2, cmp_selected2, winner_valid2, busy2, done2;
    logic [3:0]  fit_addr2, winner_idx2;
    logic [26:0] fit_data2 = '0, cmp_fitness1_2, cmp_fitness2_2;

    logic [26:0] fit [16];
    logic [15:0] m_lfsr;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    tournament_scheduler u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_parents(num_parents),
        .fit_rd_en(fit_rd_en), .fit_addr(fit_addr), .fit_data(fit_data),
        .cmp_en(cmp_en), .cmp_fitness1(cmp_fitness1), .cmp_fitness2(cmp_fitness2),
        .cmp_selected(cmp_selected), .winner_valid(winner_valid), .winner_ready(winner_ready),
        .winner_idx(winner_idx), .busy(busy), .done(done));

    tournament_scheduler #(.LFSR_SEED(16'h00FF)) u_col (
        .clk(clk), .rst_n(rst_n), .start(start2), .num_parents(8'd1),
        .fit_rd_en(fit_rd_en2), .fit_addr(fit_addr2), .fit_data(fit_data2),
        .cmp_en(cmp_en2), .cmp_fitness1(cmp_fitness1_2), .cmp_fitness2(cmp_fitness2_2),
        .cmp_selected(cmp_selected2), .winner_valid(winner_valid2), .winner_ready(1'b1),
        .winner_idx(winner_idx2), .busy(busy2), .done(done2));

    // Fitness RAM with one-cycle read latency; comparator picks lower fitness, ties to B.
    always @(posedge clk) if (fit_rd_en) fit_data <= fit[fit_addr];
    always @(posedge clk) if (fit_rd_en2) fit_data2 <= fit[fit_addr2];
    assign cmp_selected  = cmp_fitness2 <= cmp_fitness1;
    assign cmp_selected2 = cmp_fitness2_2 <= cmp_fitness1_2;

    function automatic logic [15:0] step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fit(input int mode);
        for (int i = 0; i < 16; i++)
            fit[i] = (mode == 0) ? 27'(100 * i) : (mode == 1) ? 27'd5 : 27'($urandom_range(0, 7));
    endtask

    // One draw, entered at the sample point just after the PICK transition.
    task automatic draw(input bit last_one, input int stall, input bit busy_start);
        logic [3:0] a, b, w;
        logic [3:0] q[$];
        int k;
        a = m_lfsr[3:0];
        b = m_lfsr[7:4];
        if (b == a) b = (a == 4'd15) ? 4'd0 : a + 4'd1;
        m_lfsr = step(m_lfsr);
        w = (fit[b] <= fit[a]) ? b : a;
        k = 0;
        while (!winner_valid && k < 30) begin
            if (fit_rd_en) q.push_back(fit_addr);
            tick();
            k++;
        end
        check("latency", k, 6);
        check("addr_cnt", q.size(), 2);
        if (q.size() >= 2) begin
            check("addr_a", q[0], a);
            check("addr_b", q[1], b);
        end
        check("win_idx", winner_idx, w);
        check("fit1", cmp_fitness1, fit[a]);
        check("fit2", cmp_fitness2, fit[b]);
        if (busy_start) begin
            start = 1'b1;
            num_parents = 8'd0;
            tick();
            start = 1'b0;
            check("busy_start_done", done, 0);
        end
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_valid", winner_valid, 1);
            check("stall_idx", winner_idx, w);
            check("stall_rd", fit_rd_en, 0);
            check("stall_cmp", cmp_en, 0);
        end
        winner_ready = 1'b1;
        tick();
        winner_ready = 1'b0;
        check("valid_drop", winner_valid, 0);
        check("done", done, last_one);
        check("busy_after", busy, !last_one);
        if (last_one) begin
            tick();
            check("done_pulse", done, 0);
        end
    endtask

    task automatic run(input int n, input int max_stall, input bit busy_start);
        start = 1'b1;
        num_parents = 8'(n);
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++)
            draw(i == n - 1, $urandom_range(0, max_stall), busy_start && i == 0);
    endtask

    initial begin
        logic [3:0] q2[$];
        int k;
        tick();
        check("rst_valid", winner_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd", fit_rd_en, 0);
        rst_n = 1'b1;
        m_lfsr = 16'hACE1;

        set_fit(0);
        run(1, 0, 0);
        set_fit(1);
        run(4, 2, 0);
        set_fit(2);
        start = 1'b1;
        num_parents = 8'd2;
        tick();
        start = 1'b0;
        draw(0, 10, 0);
        draw(1, 0, 0);

        start = 1'b1;
        num_parents = 8'd0;
        tick();
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        tick();
        check("zero_done_end", done, 0);
        check("zero_busy_end", busy, 0);
        run(2, 3, 1);

        for (int r = 0; r < 4; r++) begin
            set_fit(2);
            run($urandom_range(1, 5), 3, 0);
        end

        start = 1'b1;
        num_parents = 8'd3;
        tick();
        start = 1'b0;
        k = 0;
        while (!winner_valid && k < 30) begin
            tick();
            k++;
        end
        check("pre_rst_valid", winner_valid, 1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", winner_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_idx", winner_idx, 0);
        check("arst_fit1", cmp_fitness1, 0);
        check("arst_fit2", cmp_fitness2, 0);
        check("arst_addr", fit_addr, 0);
        tick();
        rst_n = 1'b1;
        m_lfsr = 16'hACE1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_done", done, 0);
            check("post_rst_busy", busy, 0);
        end
        set_fit(2);
        run(1, 1, 0);

        set_fit(0);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        k = 0;
        while (!winner_valid2 && k < 30) begin
            if (fit_rd_en2) q2.push_back(fit_addr2);
            tick();
            k++;
        end
        check("col_cnt", q2.size(), 2);
        if (q2.size() >= 2) begin
            check("col_a", q2[0], 15);
            check("col_b", q2[1], 0);
        end
        check("col_win", winner_idx2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
